serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the bit-slice of the serial arithmetic units.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one full_adder fed with ~b and a carry seeded to 1.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               fa_s;
    logic               fa_cout;
    logic               last_bit;

    full_adder u_slice (
        .a    (a_sr[0]),
        .b    (~b_sr[0]),
        .c    (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    // carry seeded to 1 supplies the +1 of the two's complement of b
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        res   <= '0;
                        cnt   <= '0;
                        carry <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff <= {fa_s, res[WIDTH-1:1]};
                        bout <= ~fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with an arithmetic reference model checked every cycle.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an accepted request yields a-b after WIDTH edges; nothing else matters.
    int               left = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_diff = '0;
    logic             m_bout = 1'b0;
    logic [WIDTH-1:0] pa = '0;
    logic [WIDTH-1:0] pb = '0;
    bit               model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            left   = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_bout = 1'b0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_done = 1'b1;
                m_diff = pa - pb;
                m_bout = (pa < pb);
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                left = WIDTH;
                pa   = a;
                pb   = b;
            end
        end
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("busy", busy, (left > 0));
            check("done", done, m_done);
            check("diff", diff, m_diff);
            check("bout", bout, m_bout);
            check("busy_and_done", busy & done, 1'b0);
        end
    end

    int busy_cnt;
    int done_cnt;

    // Issue one single-cycle request and wait for its done; returns at the done cycle's negedge.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic [WIDTH-1:0] ed, input logic eb, input string tag);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 1'b0);
        rst = 1'b0;

        run_op(8'd100, 8'd37, 8'd63, 1'b0, "t100_37");
        check("t100_37_busy_cycles", busy_cnt, 8);
        @(negedge clk);
        check("t100_37_done_pulse", done, 1'b0);

        run_op(8'd5, 8'd9, 8'hFC, 1'b1, "t5_9");
        run_op(8'd0, 8'd0, 8'h00, 1'b0, "t0_0");
        run_op(8'hFF, 8'h01, 8'hFE, 1'b0, "tFF_01");

        // second start while busy must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        check("ign_diff", diff, 8'd150);
        check("ign_bout", bout, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("ign_no_second_done", done_cnt, 0);

        // reset during the 3rd shift cycle
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd37;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_diff", diff, 8'h00);
        check("mid_rst_bout", bout, 1'b0);
        repeat (WIDTH + 2) @(negedge clk);
        check("mid_rst_stays_idle", busy | done, 1'b0);
        run_op(8'd10, 8'd3, 8'd7, 1'b0, "t10_3");

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; a = 8'd20; b = 8'd7;
        @(negedge clk);
        wait_done("b2b1");
        check("b2b1_diff", diff, 8'd13);
        check("b2b1_bout", bout, 1'b0);
        a = 8'd7; b = 8'd20;
        @(negedge clk);
        check("b2b_no_gap", busy, 1'b1);
        start = 1'b0;
        wait_done("b2b2");
        check("b2b2_busy_cycles", busy_cnt, 8);
        check("b2b2_diff", diff, 8'hF3);
        check("b2b2_bout", bout, 1'b1);
        @(negedge clk);
        check("b2b2_done_pulse", done, 1'b0);

        // start and rst together
        repeat (2) @(negedge clk);
        start = 1'b1; rst = 1'b1; a = 8'd50; b = 8'd1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("sr_busy", busy, 1'b0);
        check("sr_diff", diff, 8'h00);
        check("sr_bout", bout, 1'b0);
        @(negedge clk);
        check("sr_idle", busy | done, 1'b0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
